// File: rtl/alu_arbiter_seq.sv
// Round-robin arbiter sharing one registered 16-bit ALU between two requesters.
// Optional requester lock (carry chaining) enabled by defining ALU_ARB_LOCK_EN.
module alu_arbiter_seq #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned OPC_W  = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              req1,
   input  logic [OPC_W-1:0]  op0,
   input  logic [OPC_W-1:0]  op1,
   input  logic [DATA_W-1:0] a0,
   input  logic [DATA_W-1:0] b0,
   input  logic [DATA_W-1:0] a1,
   input  logic [DATA_W-1:0] b1,
`ifdef ALU_ARB_LOCK_EN
   input  logic              lock0,
   input  logic              lock1,
`endif
   output logic              done0,
   output logic              done1,
   output logic [DATA_W-1:0] res_out,
   output logic              res_sign,
   output logic              res_carry,
   output logic              res_zero,
   output logic              busy,
   output logic              alu_enable,
   output logic [OPC_W-1:0]  alu_opcode,
   output logic [DATA_W-1:0] alu_in_a,
   output logic [DATA_W-1:0] alu_in_b,
   input  logic [DATA_W-1:0] alu_out,
   input  logic              alu_sign,
   input  logic              alu_carry,
   input  logic              alu_zero
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_DONE} state_t;

   state_t              state_q;
   logic                prio_q;     // 0: port 0 wins a tie, 1: port 1 wins
   logic                owner_q;
   logic [OPC_W-1:0]    opc_q;
   logic [DATA_W-1:0]   ina_q;
   logic [DATA_W-1:0]   inb_q;
   logic [DATA_W-1:0]   res_q;
   logic                sign_q;
   logic                carry_q;
   logic                zero_q;
   logic                done0_q;
   logic                done1_q;

   logic                grant_vld;
   logic                grant_sel;
   logic                lock_grant;

`ifdef ALU_ARB_LOCK_EN
   logic                locked_q;
   logic                own_req;
   logic                own_lock;

   assign own_req  = owner_q ? req1  : req0;
   assign own_lock = owner_q ? lock1 : lock0;
   assign lock_grant = locked_q && own_req;
`else
   assign lock_grant = 1'b0;
`endif

   always_comb begin
      grant_vld = req0 | req1;
      grant_sel = 1'b0;
      if (lock_grant) begin
         grant_sel = owner_q;
      end else if (req0 && req1) begin
         grant_sel = prio_q;
      end else begin
         grant_sel = req1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         prio_q  <= 1'b0;
         owner_q <= 1'b0;
         opc_q   <= '0;
         ina_q   <= '0;
         inb_q   <= '0;
         res_q   <= '0;
         sign_q  <= 1'b0;
         carry_q <= 1'b0;
         zero_q  <= 1'b0;
         done0_q <= 1'b0;
         done1_q <= 1'b0;
`ifdef ALU_ARB_LOCK_EN
         locked_q <= 1'b0;
`endif
      end else begin
         done0_q <= 1'b0;
         done1_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
`ifdef ALU_ARB_LOCK_EN
               // A locked owner still gets this grant; lock is re-sampled at its DONE.
               if (locked_q && (!own_req || !own_lock)) locked_q <= 1'b0;
`endif
               if (grant_vld) begin
                  opc_q   <= grant_sel ? op1 : op0;
                  ina_q   <= grant_sel ? a1  : a0;
                  inb_q   <= grant_sel ? b1  : b0;
                  owner_q <= grant_sel;
                  if (!lock_grant) prio_q <= ~grant_sel;
                  state_q <= S_ISSUE;
               end
            end
            S_ISSUE: state_q <= S_CAPTURE;
            S_CAPTURE: begin
               res_q   <= alu_out;
               sign_q  <= alu_sign;
               carry_q <= alu_carry;
               zero_q  <= alu_zero;
               done0_q <= ~owner_q;
               done1_q <= owner_q;
               state_q <= S_DONE;
            end
            S_DONE: begin
`ifdef ALU_ARB_LOCK_EN
               locked_q <= own_lock;
`endif
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign alu_enable = (state_q == S_ISSUE);
   assign alu_opcode = opc_q;
   assign alu_in_a   = ina_q;
   assign alu_in_b   = inb_q;
   assign busy       = (state_q != S_IDLE);
   assign done0      = done0_q;
   assign done1      = done1_q;
   assign res_out    = res_q;
   assign res_sign   = sign_q;
   assign res_carry  = carry_q;
   assign res_zero   = zero_q;

endmodule
